// File: rtl/controller_poller_pkg.sv
// ---------------------------------------------------------------------------
// controller_pkg
// Shared definitions for the serial game-controller poller: the poll state
// encoding and the default timing/width parameters used by every file of
// this block.
// ---------------------------------------------------------------------------
package controller_pkg;

   // Bits shifted out of each controller on every poll.
   localparam int BUTTON_COUNT_DEFAULT = 8;

   // Clock cycles per half-period of the controller shift clock.
   localparam int CLK_DIV_DEFAULT = 64;

   // Poll sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SHIFT_LOW,
      SHIFT_HIGH,
      DONE
   } poll_state_t;

endpackage

// File: rtl/controller_poller_if.sv
// ---------------------------------------------------------------------------
// controller_poller_if
// Host-side handshake of the controller poller.
//   start                : poll request from the host
//   busy                 : a poll is in progress
//   done                 : one-cycle pulse when new button bytes are published
//   controller_1_buttons : published state of controller 1 (1 = pressed)
//   controller_2_buttons : published state of controller 2 (1 = pressed)
// Modports: master = host side, slave = poller side.
// ---------------------------------------------------------------------------
interface controller_poller_if
   import controller_pkg::*;
#(
   parameter int BUTTON_COUNT = BUTTON_COUNT_DEFAULT
);

   logic                    start;
   logic                    busy;
   logic                    done;
   logic [BUTTON_COUNT-1:0] controller_1_buttons;
   logic [BUTTON_COUNT-1:0] controller_2_buttons;

   modport master (
      output start,
      input  busy,
      input  done,
      input  controller_1_buttons,
      input  controller_2_buttons
   );

   modport slave (
      input  start,
      output busy,
      output done,
      output controller_1_buttons,
      output controller_2_buttons
   );

endinterface

// File: rtl/controller_poller_shift_in.sv
// ---------------------------------------------------------------------------
// controller_shift_in
// Per-controller receive path: a two-flop synchroniser for the asynchronous
// active-low serial data line, followed by an MSB-first shift register.
//   clk_12_5875 : system clock
//   rst         : synchronous active-high reset
//   data_in_B   : serial data from the controller, active-low, asynchronous
//   shift_en    : take one bit this cycle
//   shift_next  : the full button word as it will look once the bit being
//                 taken this cycle is included (active-high)
// ---------------------------------------------------------------------------
module controller_shift_in
   import controller_pkg::*;
#(
   parameter int BUTTON_COUNT = BUTTON_COUNT_DEFAULT
)(
   input  logic                    clk_12_5875,
   input  logic                    rst,
   input  logic                    data_in_B,
   input  logic                    shift_en,
   output logic [BUTTON_COUNT-1:0] shift_next
);

   logic                    sync_1;
   logic                    sync_2;
   logic [BUTTON_COUNT-2:0] shift_reg;

   // The register only keeps the bits gathered so far (one fewer than a full
   // word). The last bit joins them through shift_next on the same edge the
   // poller publishes, so the published word and done appear together.
   assign shift_next = {shift_reg, ~sync_2};

   // Synchroniser flops reset to 1 (line released, no button pressed); the
   // shift register moves left so the first sampled bit ends up in the MSB.
   always_ff @(posedge clk_12_5875) begin
      if (rst) begin
         sync_1    <= 1'b1;
         sync_2    <= 1'b1;
         shift_reg <= '0;
      end else begin
         sync_1 <= data_in_B;
         sync_2 <= sync_1;
         if (shift_en) begin
            shift_reg <= shift_next[BUTTON_COUNT-2:0];
         end
      end
   end

endmodule

// File: rtl/controller_poller.sv
// ---------------------------------------------------------------------------
// controller_poller
// Polls two serial game controllers on request. A poll raises the latch strobe
// for one divider period, then produces BUTTON_COUNT-1 shift-clock pulses,
// sampling one bit per controller at the end of every low half-period, and
// finally publishes both button words together with a one-cycle done pulse.
//   clk_12_5875            : sole clock, rising-edge
//   rst                    : synchronous active-high reset
//   host                   : start/busy/done/button handshake (slave modport)
//   controller_latch       : parallel-load strobe to both controllers
//   controller_clk         : shift clock to both controllers
//   controller_1_data_in_B : serial data of controller 1, active-low
//   controller_2_data_in_B : serial data of controller 2, active-low
// ---------------------------------------------------------------------------
module controller_poller
   import controller_pkg::*;
#(
   parameter int CLK_DIV      = CLK_DIV_DEFAULT,
   parameter int BUTTON_COUNT = BUTTON_COUNT_DEFAULT
)(
   input  logic               clk_12_5875,
   input  logic               rst,
   controller_poller_if.slave host,
   output logic               controller_latch,
   output logic               controller_clk,
   input  logic               controller_1_data_in_B,
   input  logic               controller_2_data_in_B
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int CNT_W = $clog2(BUTTON_COUNT + 1);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(BUTTON_COUNT - 1);

   poll_state_t             state;
   logic [DIV_W-1:0]        div_cnt;
   logic [CNT_W-1:0]        bit_cnt;
   logic                    div_expired;
   logic                    shift_en;
   logic [BUTTON_COUNT-1:0] c1_next;
   logic [BUTTON_COUNT-1:0] c2_next;

   // The divider counts down from CLK_DIV-1 after every state entry, so a
   // timed state ends in the cycle where it reads zero.
   assign div_expired = (div_cnt == '0);

   // Bits are taken in the last cycle of each low half-period, the point
   // furthest from the controller's own shift edge.
   assign shift_en = (state == SHIFT_LOW) && div_expired;

   controller_shift_in #(
      .BUTTON_COUNT (BUTTON_COUNT)
   ) u_controller_1 (
      .clk_12_5875 (clk_12_5875),
      .rst         (rst),
      .data_in_B   (controller_1_data_in_B),
      .shift_en    (shift_en),
      .shift_next  (c1_next)
   );

   controller_shift_in #(
      .BUTTON_COUNT (BUTTON_COUNT)
   ) u_controller_2 (
      .clk_12_5875 (clk_12_5875),
      .rst         (rst),
      .data_in_B   (controller_2_data_in_B),
      .shift_en    (shift_en),
      .shift_next  (c2_next)
   );

   // Poll sequencer. Every output is set on the transition into the state
   // that owns it, so all pins come straight from flops. start is only looked
   // at in IDLE, which makes requests during a poll (DONE included) vanish
   // and leaves exactly one IDLE cycle between back-to-back polls. Reset
   // drops everything in the next cycle, discarding any partial result.
   always_ff @(posedge clk_12_5875) begin
      if (rst) begin
         state                     <= IDLE;
         div_cnt                   <= '0;
         bit_cnt                   <= '0;
         controller_latch          <= 1'b0;
         controller_clk            <= 1'b0;
         host.busy                 <= 1'b0;
         host.done                 <= 1'b0;
         host.controller_1_buttons <= '0;
         host.controller_2_buttons <= '0;
      end else begin
         host.done <= 1'b0;
         case (state)
            IDLE: begin
               if (host.start) begin
                  state            <= LATCH;
                  div_cnt          <= DIV_RELOAD;
                  bit_cnt          <= '0;
                  controller_latch <= 1'b1;
                  host.busy        <= 1'b1;
               end
            end

            LATCH: begin
               if (div_expired) begin
                  state            <= SHIFT_LOW;
                  div_cnt          <= DIV_RELOAD;
                  controller_latch <= 1'b0;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end

            SHIFT_LOW: begin
               if (div_expired) begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  div_cnt <= DIV_RELOAD;
                  if (bit_cnt == LAST_BIT) begin
                     state                     <= DONE;
                     host.done                 <= 1'b1;
                     host.controller_1_buttons <= c1_next;
                     host.controller_2_buttons <= c2_next;
                  end else begin
                     state          <= SHIFT_HIGH;
                     controller_clk <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end

            SHIFT_HIGH: begin
               if (div_expired) begin
                  state          <= SHIFT_LOW;
                  div_cnt        <= DIV_RELOAD;
                  controller_clk <= 1'b0;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end

            DONE: begin
               state     <= IDLE;
               div_cnt   <= DIV_RELOAD;
               host.busy <= 1'b0;
            end

            default: begin
               state            <= IDLE;
               div_cnt          <= DIV_RELOAD;
               controller_latch <= 1'b0;
               controller_clk   <= 1'b0;
               host.busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controller_poller.sv
// ---------------------------------------------------------------------------
// tb_controller_poller
// Self-checking bench for controller_poller with CLK_DIV=4, BUTTON_COUNT=8.
// Two behavioural controllers load their pattern while latch is high and
// shift left on each rising controller_clk, driving the inverted MSB.
// ---------------------------------------------------------------------------
module tb_controller_poller;

   logic clk_12_5875;
   logic rst;
   logic controller_latch;
   logic controller_clk;
   logic controller_1_data_in_B;
   logic controller_2_data_in_B;

   controller_poller_if #(.BUTTON_COUNT(8)) bus ();

   controller_poller #(
      .CLK_DIV      (4),
      .BUTTON_COUNT (8)
   ) dut (
      .clk_12_5875            (clk_12_5875),
      .rst                    (rst),
      .host                   (bus.slave),
      .controller_latch       (controller_latch),
      .controller_clk         (controller_clk),
      .controller_1_data_in_B (controller_1_data_in_B),
      .controller_2_data_in_B (controller_2_data_in_B)
   );

   initial clk_12_5875 = 1'b0;
   always #5 clk_12_5875 = ~clk_12_5875;

   // Behavioural controllers: parallel load while latched, shift on the
   // rising edge of the shift clock, active-low serial output.
   logic [7:0] ctrl1_pat;
   logic [7:0] ctrl2_pat;
   logic [7:0] model1;
   logic [7:0] model2;
   logic       model_prev_cclk;

   initial begin
      model1          = 8'h00;
      model2          = 8'h00;
      model_prev_cclk = 1'b0;
   end

   always @(posedge clk_12_5875) begin
      if (controller_latch) begin
         model1 <= ctrl1_pat;
         model2 <= ctrl2_pat;
      end else if (controller_clk && !model_prev_cclk) begin
         model1 <= {model1[6:0], 1'b0};
         model2 <= {model2[6:0], 1'b0};
      end
      model_prev_cclk <= controller_clk;
   end

   assign controller_1_data_in_B = ~model1[7];
   assign controller_2_data_in_B = ~model2[7];

   int checks = 0;
   int passes = 0;

   // Results of the most recent applyStimulus call.
   int         res_latency;
   int         res_latch;
   int         res_rises;
   int         res_bad_runs;
   int         res_early;
   int         res_extra;
   int         res_busy_gaps;
   logic [7:0] res_b1;
   logic [7:0] res_b2;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // One poll with a single start pulse. mid_start != 0 raises start again
   // for one cycle at that sample index. Records latency to done, waveform
   // shape, early button changes, and activity in 20 cycles after done.
   task automatic applyStimulus(input logic [7:0] p1, input logic [7:0] p2,
                                input int mid_start);
      logic [7:0] old1;
      logic [7:0] old2;
      logic       prev_cclk;
      int         run;
      ctrl1_pat     = p1;
      ctrl2_pat     = p2;
      old1          = bus.controller_1_buttons;
      old2          = bus.controller_2_buttons;
      res_latency   = 0;
      res_latch     = 0;
      res_rises     = 0;
      res_bad_runs  = 0;
      res_early     = 0;
      res_extra     = 0;
      res_busy_gaps = 0;
      res_b1        = 8'h00;
      res_b2        = 8'h00;
      prev_cclk     = 1'b0;
      run           = 0;
      bus.start     = 1'b1;
      for (int n = 1; n <= 2000 && res_latency == 0; n++) begin
         @(posedge clk_12_5875);
         #1;
         if (n == 1) bus.start = 1'b0;
         if (mid_start != 0 && n == mid_start) bus.start = 1'b1;
         if (mid_start != 0 && n == mid_start + 1) bus.start = 1'b0;
         if (controller_latch) res_latch++;
         if (controller_clk != prev_cclk) begin
            if (controller_clk) begin
               if (res_rises > 0 && run != 4) res_bad_runs++;
               res_rises++;
            end else if (run != 4) begin
               res_bad_runs++;
            end
            run = 1;
         end else begin
            run++;
         end
         prev_cclk = controller_clk;
         if (!bus.busy) res_busy_gaps++;
         if (bus.done) begin
            res_latency = n;
            res_b1      = bus.controller_1_buttons;
            res_b2      = bus.controller_2_buttons;
         end else if (bus.controller_1_buttons != old1 ||
                      bus.controller_2_buttons != old2) begin
            res_early++;
         end
      end
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk_12_5875);
         #1;
         if (k == 1) begin
            bus.start = 1'b0;
            if (bus.busy) res_busy_gaps++;
         end
         if (bus.done || controller_latch) res_extra++;
      end
   endtask

   typedef struct {
      logic [7:0] pat1;
      logic [7:0] pat2;
      logic [7:0] exp1;
      logic [7:0] exp2;
      int         mid_start;
   } vector_t;

   vector_t vectors[5];

   initial begin
      int         d1;
      int         d2;
      int         d3;
      int         dones;
      int         extra;
      logic [7:0] cb1[3];
      logic [7:0] cb2[3];

      vectors[0] = '{8'h88, 8'h26, 8'h88, 8'h26, 0};
      vectors[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 0};
      vectors[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 20};
      vectors[3] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 65};
      vectors[4] = '{8'h01, 8'h80, 8'h01, 8'h80, 0};

      ctrl1_pat = 8'h00;
      ctrl2_pat = 8'h00;
      bus.start = 1'b0;
      rst       = 1'b1;
      repeat (3) @(posedge clk_12_5875);
      #1;
      checkOutput("reset_latch", {31'd0, controller_latch}, 32'd0);
      checkOutput("reset_cclk", {31'd0, controller_clk}, 32'd0);
      checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
      checkOutput("reset_btn1", {24'd0, bus.controller_1_buttons}, 32'd0);
      checkOutput("reset_btn2", {24'd0, bus.controller_2_buttons}, 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk_12_5875);
      #1;

      $display("[TB] table-driven polls");
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vectors[v].pat1, vectors[v].pat2, vectors[v].mid_start);
         checkOutput($sformatf("v%0d_latency", v), res_latency, 32'd65);
         checkOutput($sformatf("v%0d_btn1", v), {24'd0, res_b1}, {24'd0, vectors[v].exp1});
         checkOutput($sformatf("v%0d_btn2", v), {24'd0, res_b2}, {24'd0, vectors[v].exp2});
         checkOutput($sformatf("v%0d_latch_cycles", v), res_latch, 32'd4);
         checkOutput($sformatf("v%0d_cclk_pulses", v), res_rises, 32'd7);
         checkOutput($sformatf("v%0d_bad_halfperiods", v), res_bad_runs, 32'd0);
         checkOutput($sformatf("v%0d_early_change", v), res_early, 32'd0);
         checkOutput($sformatf("v%0d_extra_activity", v), res_extra, 32'd0);
         checkOutput($sformatf("v%0d_busy_profile", v), res_busy_gaps, 32'd0);
      end

      $display("[TB] reset in the middle of a poll");
      ctrl1_pat = 8'h5A;
      ctrl2_pat = 8'hC3;
      bus.start = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk_12_5875);
         #1;
         if (n == 1) bus.start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk_12_5875);
      #1;
      checkOutput("midrst_latch", {31'd0, controller_latch}, 32'd0);
      checkOutput("midrst_cclk", {31'd0, controller_clk}, 32'd0);
      checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("midrst_done", {31'd0, bus.done}, 32'd0);
      checkOutput("midrst_btn1", {24'd0, bus.controller_1_buttons}, 32'd0);
      checkOutput("midrst_btn2", {24'd0, bus.controller_2_buttons}, 32'd0);
      rst   = 1'b0;
      extra = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk_12_5875);
         #1;
         if (bus.done || controller_latch || bus.busy) extra++;
      end
      checkOutput("midrst_no_activity", extra, 32'd0);

      $display("[TB] continuous polling");
      ctrl1_pat = 8'h5A;
      ctrl2_pat = 8'hC3;
      d1        = 0;
      d2        = 0;
      d3        = 0;
      dones     = 0;
      bus.start = 1'b1;
      for (int n = 1; n <= 400 && dones < 3; n++) begin
         @(posedge clk_12_5875);
         #1;
         if (bus.done) begin
            cb1[dones] = bus.controller_1_buttons;
            cb2[dones] = bus.controller_2_buttons;
            if (dones == 0) d1 = n;
            if (dones == 1) d2 = n;
            if (dones == 2) d3 = n;
            dones++;
            if (dones == 3) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      checkOutput("cont_done_count", dones, 32'd3);
      checkOutput("cont_first_latency", d1, 32'd65);
      checkOutput("cont_spacing_1_2", d2 - d1, 32'd66);
      checkOutput("cont_spacing_2_3", d3 - d2, 32'd66);
      for (int i = 0; i < 3; i++) begin
         if (i < dones) begin
            checkOutput($sformatf("cont_btn1_%0d", i), {24'd0, cb1[i]}, 32'h5A);
            checkOutput($sformatf("cont_btn2_%0d", i), {24'd0, cb2[i]}, 32'hC3);
         end
      end
      extra = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk_12_5875);
         #1;
         if (bus.done || controller_latch) extra++;
      end
      checkOutput("cont_stops_after_release", extra, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
